// File: rtl/tsmac_fifo_arb_pkg.sv
// Shared types and defaults for the two-requester TSMAC FIFO write arbiter.
// Holds the arbiter FSM states, the requester index type and width defaults.
package tsmac_fifo_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  typedef logic port_idx_t;

  function automatic logic [1:0] port_onehot(input port_idx_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tsmac_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the rr port.
// When nothing is requested sel is don't-care and simply follows rr.
module tsmac_rr_arb2
  import tsmac_fifo_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  rr,
  output port_idx_t  sel
);

  always_comb begin
    sel = rr;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = rr;
    endcase
  end

endmodule

// File: rtl/tsmac_fifo_wr_arb.sv
// Frame-atomic arbiter merging two beat streams into one SYN FIFO write port.
// A frame owns the FIFO from SOF to EOF; almost-full only gates frame admission.
module tsmac_fifo_wr_arb
  import tsmac_fifo_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_sof,
  input  logic              s0_eof,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_sof,
  input  logic              s1_eof,
  output logic              s1_ready,
  output logic              fifo_wr_en,
  output logic [DATA_W:0]   fifo_wr_data,
  input  logic              fifo_wr_full,
  input  logic              fifo_almost_full,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1,
  output logic              err_stray,
  output logic              err_sof
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_reg, state_next;
  port_idx_t        owner_reg, owner_next;
  port_idx_t        rr_reg, rr_next;
  port_idx_t        arb_sel;
  logic             first_reg, first_next;
  logic [CNT_W-1:0] frame_cnt0_reg, frame_cnt0_next;
  logic [CNT_W-1:0] frame_cnt1_reg, frame_cnt1_next;

  logic [1:0] valid_vec, sof_vec, eof_vec;
  logic [1:0] cand_vec, stray_vec;
  logic [1:0] ready_vec;
  logic [1:0] grant_vec;
  logic       wr_en_c, stray_c, sof_err_c, accept;

  logic              owner_valid, owner_sof, owner_eof;
  logic [DATA_W-1:0] owner_data;

  assign valid_vec = {s1_valid, s0_valid};
  assign sof_vec   = {s1_sof,   s0_sof};
  assign eof_vec   = {s1_eof,   s0_eof};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign cand_vec[gi]  = valid_vec[gi] &  sof_vec[gi];
      assign stray_vec[gi] = valid_vec[gi] & ~sof_vec[gi];
    end
  endgenerate

  tsmac_rr_arb2 u_rr_arb (
    .req (cand_vec),
    .rr  (rr_reg),
    .sel (arb_sel)
  );

  assign owner_valid = valid_vec[owner_reg];
  assign owner_sof   = sof_vec[owner_reg];
  assign owner_eof   = eof_vec[owner_reg];
  assign owner_data  = owner_reg ? s1_data : s0_data;

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    rr_next         = rr_reg;
    first_next      = first_reg;
    frame_cnt0_next = frame_cnt0_reg;
    frame_cnt1_next = frame_cnt1_reg;
    ready_vec       = 2'b00;
    grant_vec       = 2'b00;
    wr_en_c         = 1'b0;
    stray_c         = 1'b0;
    sof_err_c       = 1'b0;
    accept          = 1'b0;

    case (state_reg)
      IDLE: begin
        // Stray beats are swallowed; SOF beats wait for the first XFER cycle.
        ready_vec = stray_vec;
        stray_c   = |stray_vec;
        if (!fifo_almost_full && (|cand_vec)) begin
          state_next = XFER;
          owner_next = arb_sel;
          first_next = 1'b1;
        end
      end
      XFER: begin
        grant_vec            = port_onehot(owner_reg);
        ready_vec[owner_reg] = ~fifo_wr_full;
        accept               = owner_valid & ~fifo_wr_full;
        wr_en_c              = accept;
        if (accept) begin
          first_next = 1'b0;
          sof_err_c  = owner_sof & ~first_reg;
          if (owner_eof) begin
            state_next = IDLE;
            rr_next    = ~owner_reg;
            if (owner_reg) frame_cnt1_next = frame_cnt1_reg + CNT_ONE;
            else           frame_cnt0_next = frame_cnt0_reg + CNT_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Handshake outputs must be quiet for the whole reset, not just after it.
    if (!rst_n) begin
      ready_vec = 2'b00;
      grant_vec = 2'b00;
      wr_en_c   = 1'b0;
      stray_c   = 1'b0;
      sof_err_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      rr_reg         <= 1'b0;
      first_reg      <= 1'b0;
      frame_cnt0_reg <= '0;
      frame_cnt1_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      rr_reg         <= rr_next;
      first_reg      <= first_next;
      frame_cnt0_reg <= frame_cnt0_next;
      frame_cnt1_reg <= frame_cnt1_next;
    end
  end

  assign s0_ready     = ready_vec[0];
  assign s1_ready     = ready_vec[1];
  assign grant        = grant_vec;
  assign fifo_wr_en   = wr_en_c;
  assign fifo_wr_data = {owner_eof, owner_data};
  assign err_stray    = stray_c;
  assign err_sof      = sof_err_c;
  assign frame_cnt0   = frame_cnt0_reg;
  assign frame_cnt1   = frame_cnt1_reg;

endmodule

// File: tb/tb_tsmac_fifo_wr_arb.sv
// Directed bench for tsmac_fifo_wr_arb: queued beat sources per port, a FIFO
// write log, and hand-computed grant/ready/counter expectations per scenario.
module tb_tsmac_fifo_wr_arb;

  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eof;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          s0_valid, s0_sof, s0_eof, s0_ready;
  logic          s1_valid, s1_sof, s1_eof, s1_ready;
  logic [DW-1:0] s0_data, s1_data;
  logic          fifo_wr_en, fifo_wr_full, fifo_almost_full;
  logic [DW:0]   fifo_wr_data;
  logic [1:0]    grant;
  logic [CW-1:0] frame_cnt0, frame_cnt1;
  logic          err_stray, err_sof;

  tsmac_fifo_wr_arb #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s0_valid         (s0_valid),
    .s0_data          (s0_data),
    .s0_sof           (s0_sof),
    .s0_eof           (s0_eof),
    .s0_ready         (s0_ready),
    .s1_valid         (s1_valid),
    .s1_data          (s1_data),
    .s1_sof           (s1_sof),
    .s1_eof           (s1_eof),
    .s1_ready         (s1_ready),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_wr_full     (fifo_wr_full),
    .fifo_almost_full (fifo_almost_full),
    .grant            (grant),
    .frame_cnt0       (frame_cnt0),
    .frame_cnt1       (frame_cnt1),
    .err_stray        (err_stray),
    .err_sof          (err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [DW:0] wlog[$];
  logic [DW:0] explog[$];
  int          checks = 0;
  int          errors = 0;

  logic [1:0] cur_grant;
  logic       cur_r0, cur_r1, cur_wr, cur_stray, cur_sof;
  logic [1:0] gseq [9];
  logic [1:0] exp_g [9];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic s, input logic e);
    beat_t b;
    b.d   = d;
    b.sof = s;
    b.eof = e;
    return b;
  endfunction

  task automatic push0(input logic [DW-1:0] d, input logic s, input logic e);
    q0.push_back(mk(d, s, e));
    explog.push_back({e, d});
  endtask

  task automatic push1(input logic [DW-1:0] d, input logic s, input logic e);
    q1.push_back(mk(d, s, e));
    explog.push_back({e, d});
  endtask

  // One clock: drive port heads at negedge, sample 1ns later, pop consumed beats.
  task automatic cycle(input logic full, input logic af);
    @(negedge clk);
    fifo_wr_full     = full;
    fifo_almost_full = af;
    if (q0.size() > 0) begin
      s0_valid = 1'b1; s0_data = q0[0].d; s0_sof = q0[0].sof; s0_eof = q0[0].eof;
    end else begin
      s0_valid = 1'b0; s0_sof = 1'b0; s0_eof = 1'b0;
    end
    if (q1.size() > 0) begin
      s1_valid = 1'b1; s1_data = q1[0].d; s1_sof = q1[0].sof; s1_eof = q1[0].eof;
    end else begin
      s1_valid = 1'b0; s1_sof = 1'b0; s1_eof = 1'b0;
    end
    #1;
    cur_grant = grant;
    cur_r0    = s0_ready;
    cur_r1    = s1_ready;
    cur_wr    = fifo_wr_en;
    cur_stray = err_stray;
    cur_sof   = err_sof;
    if (fifo_wr_en) begin
      wlog.push_back(fifo_wr_data);
      $display("wr beat data=%h eof=%b grant=%b", fifo_wr_data[DW-1:0], fifo_wr_data[DW], grant);
    end
    if (s0_valid && s0_ready) q0.delete(0);
    if (s1_valid && s1_ready) q1.delete(0);
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_len"}, 64'(wlog.size()), 64'(explog.size()));
    for (int i = 0; i < wlog.size() && i < explog.size(); i++)
      check_val($sformatf("%s_beat%0d", tag, i), 64'(wlog[i]), 64'(explog[i]));
    wlog.delete();
    explog.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    s0_valid = 0; s0_data = '0; s0_sof = 0; s0_eof = 0;
    s1_valid = 0; s1_data = '0; s1_sof = 0; s1_eof = 0;
    fifo_wr_full = 0; fifo_almost_full = 0;

    // Reset state
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("rst_grant", 64'(cur_grant), 64'd0);
    check_val("rst_wr_en", 64'(cur_wr), 64'd0);
    check_val("rst_cnt0", 64'(frame_cnt0), 64'd0);
    check_val("rst_cnt1", 64'(frame_cnt1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous 3-beat frames: port 0 first, then port 1
    push0(32'hA000_0000, 1'b1, 1'b0);
    push0(32'hA000_0001, 1'b0, 1'b0);
    push0(32'hA000_0002, 1'b0, 1'b1);
    push1(32'hB000_0000, 1'b1, 1'b0);
    push1(32'hB000_0001, 1'b0, 1'b0);
    push1(32'hB000_0002, 1'b0, 1'b1);
    exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0);
      gseq[i] = cur_grant;
    end
    for (int i = 0; i < 9; i++)
      check_val($sformatf("dual_grant%0d", i), 64'(gseq[i]), 64'(exp_g[i]));
    check_log("dual");
    check_val("dual_cnt0", 64'(frame_cnt0), 64'd1);
    check_val("dual_cnt1", 64'(frame_cnt1), 64'd1);

    // Four-cycle FIFO-full stall mid-frame
    push0(32'hC000_0000, 1'b1, 1'b0);
    push0(32'hC000_0001, 1'b0, 1'b0);
    push0(32'hC000_0002, 1'b0, 1'b0);
    push0(32'hC000_0003, 1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("stall_pre_wr", 64'(cur_wr), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      check_val($sformatf("stall_ready%0d", i), 64'(cur_r0), 64'd0);
      check_val($sformatf("stall_wr%0d", i), 64'(cur_wr), 64'd0);
    end
    cycle(1'b0, 1'b0);
    check_val("stall_resume_ready", 64'(cur_r0), 64'd1);
    check_val("stall_resume_wr", 64'(cur_wr), 64'd1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_log("stall");
    check_val("stall_cnt0", 64'(frame_cnt0), 64'd2);

    // Almost-full holds off admission; ignored once the frame is owned
    push1(32'hD000_0000, 1'b1, 1'b0);
    push1(32'hD000_0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1);
      check_val($sformatf("af_grant%0d", i), 64'(cur_grant), 64'd0);
      check_val($sformatf("af_ready%0d", i), 64'(cur_r1), 64'd0);
    end
    cycle(1'b0, 1'b0);
    check_val("af_drop_grant", 64'(cur_grant), 64'd0);
    cycle(1'b0, 1'b1);
    check_val("af_xfer_grant", 64'(cur_grant), 64'b10);
    check_val("af_xfer_wr", 64'(cur_wr), 64'd1);
    cycle(1'b0, 1'b1);
    check_val("af_eof_wr", 64'(cur_wr), 64'd1);
    cycle(1'b0, 1'b0);
    check_val("af_idle_grant", 64'(cur_grant), 64'd0);
    check_log("af");
    check_val("af_cnt1", 64'(frame_cnt1), 64'd2);

    // Stray beat in IDLE
    q0.push_back(mk(32'hE000_0000, 1'b0, 1'b0));
    cycle(1'b0, 1'b0);
    check_val("stray_ready", 64'(cur_r0), 64'd1);
    check_val("stray_pulse", 64'(cur_stray), 64'd1);
    check_val("stray_wr", 64'(cur_wr), 64'd0);
    check_val("stray_grant", 64'(cur_grant), 64'd0);
    cycle(1'b0, 1'b0);
    check_val("stray_pulse_end", 64'(cur_stray), 64'd0);

    // SOF inside a frame is data plus an error pulse
    push0(32'hF000_0000, 1'b1, 1'b0);
    push0(32'hF000_0001, 1'b1, 1'b0);
    push0(32'hF000_0002, 1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("sof_first_noerr", 64'(cur_sof), 64'd0);
    cycle(1'b0, 1'b0);
    check_val("sof_mid_err", 64'(cur_sof), 64'd1);
    check_val("sof_mid_wr", 64'(cur_wr), 64'd1);
    cycle(1'b0, 1'b0);
    check_val("sof_err_end", 64'(cur_sof), 64'd0);
    cycle(1'b0, 1'b0);
    check_log("sof");
    check_val("sof_cnt0", 64'(frame_cnt0), 64'd3);

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.frame_cnt0_reg = 16'hFFFF;
    #1;
    release dut.frame_cnt0_reg;
    check_val("wrap_preload", 64'(frame_cnt0), 64'hFFFF);
    push0(32'h1234_5678, 1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("wrap_1beat_wr", 64'(cur_wr), 64'd1);
    cycle(1'b0, 1'b0);
    check_log("wrap");
    check_val("wrap_cnt0", 64'(frame_cnt0), 64'd0);
    check_val("wrap_cnt1", 64'(frame_cnt1), 64'd2);

    // Reset on beat 2 of a 4-beat frame, then a fresh s1 frame
    q0.push_back(mk(32'h5000_0000, 1'b1, 1'b0));
    q0.push_back(mk(32'h5000_0001, 1'b0, 1'b0));
    q0.push_back(mk(32'h5000_0002, 1'b0, 1'b0));
    q0.push_back(mk(32'h5000_0003, 1'b0, 1'b1));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    s0_valid = 1'b1; s0_data = q0[0].d; s0_sof = 1'b0; s0_eof = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("mrst_grant", 64'(grant), 64'd0);
    check_val("mrst_wr", 64'(fifo_wr_en), 64'd0);
    check_val("mrst_r0", 64'(s0_ready), 64'd0);
    check_val("mrst_r1", 64'(s1_ready), 64'd0);
    check_val("mrst_stray", 64'(err_stray), 64'd0);
    check_val("mrst_sof", 64'(err_sof), 64'd0);
    check_val("mrst_cnt0", 64'(frame_cnt0), 64'd0);
    check_val("mrst_cnt1", 64'(frame_cnt1), 64'd0);
    q0.delete();
    wlog.delete();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push1(32'h9000_0000, 1'b1, 1'b0);
    push1(32'h9000_0001, 1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check_val("post_idle_grant", 64'(cur_grant), 64'd0);
    cycle(1'b0, 1'b0);
    check_val("post_grant", 64'(cur_grant), 64'b10);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_log("post");
    check_val("post_cnt1", 64'(frame_cnt1), 64'd1);
    check_val("post_cnt0", 64'(frame_cnt0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
